button_debounce_bank: RTL and testbench

//  Parametrised N-channel button front end: 2-FF synchronizer, then per-channel

---
 rtl/button_debounce_bank.sv | 133 +++++++++++++
 tb/tb_button_debounce_bank.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_bank.sv
// N-channel button front end: 2-FF synchronizer, per-channel debounce, registered level and press/release pulses.
// Define BTN_AUTOREPEAT_EN to add per-channel auto-repeat press pulses while a button is held.
module button_debounce_bank #(
  parameter int N_BTN      = 5,
  parameter int DB_CYCLES  = 65536,
  parameter int ACTIVE_LOW = 0,
  parameter int RPT_DELAY  = 5000000,
  parameter int RPT_PERIOD = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic             any_press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  localparam logic [N_BTN-1:0] POL = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

  logic [N_BTN-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic             any_q, any_d;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] rise;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
  localparam int RW = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] RPT_DELAY_M1  = RW'(RPT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_M1 = RW'(RPT_PERIOD - 1);

  logic [RW-1:0]    rpt_q [N_BTN];
  logic [RW-1:0]    rpt_d [N_BTN];
  logic [N_BTN-1:0] rpt_first_q, rpt_first_d;
  logic [N_BTN-1:0] rpt_fire;
`endif

  // Synchronizer, debounce counters and edge/repeat decode
  always_comb begin
    s1_d    = btn_raw ^ POL;
    s2_d    = s1_q;
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        level_d[i] = s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    rise      = level_d & ~level_q;
    release_d = level_q & ~level_d;
`ifdef BTN_AUTOREPEAT_EN
    for (int i = 0; i < N_BTN; i++) begin
      rpt_d[i]       = rpt_q[i];
      rpt_first_d[i] = rpt_first_q[i];
      rpt_fire[i]    = 1'b0;
      // timer counts cycles since the last press pulse; a releasing channel never fires
      if (rise[i] || !level_d[i]) begin
        rpt_d[i]       = '0;
        rpt_first_d[i] = 1'b1;
      end else if (rpt_q[i] == (rpt_first_q[i] ? RPT_DELAY_M1 : RPT_PERIOD_M1)) begin
        rpt_fire[i]    = 1'b1;
        rpt_d[i]       = '0;
        rpt_first_d[i] = 1'b0;
      end else begin
        rpt_d[i] = rpt_q[i] + RW'(1);
      end
    end
    press_d = rise | rpt_fire;
`else
    press_d = rise;
`endif
    any_d = |press_d;
  end

  // Main state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  // Auto-repeat timers
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_first_q <= {N_BTN{1'b1}};
      for (int i = 0; i < N_BTN; i++) begin
        rpt_q[i] <= '0;
      end
    end else begin
      rpt_first_q <= rpt_first_d;
      for (int i = 0; i < N_BTN; i++) begin
        rpt_q[i] <= rpt_d[i];
      end
    end
  end
`endif

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign any_press   = any_q;

endmodule

// File: tb/tb_button_debounce_bank.sv
// Scoreboard bench for button_debounce_bank: a window-based reference model pushes expected outputs per cycle.
// Two instances cover ACTIVE_LOW=0 and ACTIVE_LOW=1; BTN_AUTOREPEAT_EN selects repeat expectations.
module tb_button_debounce_bank;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT_EN = 1'b1;
`else
  localparam bit RPT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] raw_a, raw_b;
  logic [1:0] lvl_a, prs_a, rel_a, lvl_b, prs_b, rel_b;
  logic       any_a, any_b;

  button_debounce_bank #(.N_BTN(2), .DB_CYCLES(DB), .ACTIVE_LOW(0), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut_a (
    .clk(clk), .reset(reset), .btn_raw(raw_a), .btn_level(lvl_a),
    .btn_press(prs_a), .btn_release(rel_a), .any_press(any_a)
  );

  button_debounce_bank #(.N_BTN(2), .DB_CYCLES(DB), .ACTIVE_LOW(1), .RPT_DELAY(RD), .RPT_PERIOD(RP)) dut_b (
    .clk(clk), .reset(reset), .btn_raw(raw_b), .btn_level(lvl_b),
    .btn_press(prs_b), .btn_release(rel_b), .any_press(any_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model state, index [dut][channel]
  logic [1:0]    m_s1 [2];
  logic [1:0]    m_s2 [2];
  logic [1:0]    m_lvl [2];
  logic [DB-1:0] m_hist [2][2];
  int            m_valid [2][2];
  int            m_hold [2][2];
  logic          m_al [2] = '{1'b0, 1'b1};
  logic [6:0]    exp_q [$];

  int seg_cyc, press0_cnt, first_press0, both_press, both_rel;

  // level flips once the last DB synchronized samples all disagree with it
  task automatic model_step(input int d, input logic r, input logic [1:0] pin);
    logic [1:0]    pr, rl;
    logic [DB-1:0] want;
    pr = 2'b00;
    rl = 2'b00;
    if (r) begin
      m_s1[d]  = 2'b00;
      m_s2[d]  = 2'b00;
      m_lvl[d] = 2'b00;
      for (int c = 0; c < 2; c++) begin
        m_hist[d][c]  = '0;
        m_valid[d][c] = 0;
        m_hold[d][c]  = 0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_hist[d][c] = {m_hist[d][c][DB-2:0], m_s2[d][c]};
        if (m_valid[d][c] < DB) m_valid[d][c]++;
        want = m_lvl[d][c] ? {DB{1'b0}} : {DB{1'b1}};
        if (m_valid[d][c] == DB && m_hist[d][c] == want) begin
          m_lvl[d][c]   = ~m_lvl[d][c];
          m_valid[d][c] = 0;
          if (m_lvl[d][c]) begin
            pr[c] = 1'b1;
            m_hold[d][c] = 0;
          end else begin
            rl[c] = 1'b1;
          end
        end else if (m_lvl[d][c] && RPT_EN) begin
          m_hold[d][c]++;
          if (m_hold[d][c] == RD || (m_hold[d][c] > RD && (m_hold[d][c] - RD) % RP == 0)) pr[c] = 1'b1;
        end
      end
      m_s2[d] = m_s1[d];
      m_s1[d] = pin ^ {2{m_al[d]}};
    end
    exp_q.push_back({m_lvl[d], pr, rl, |pr});
  endtask

  task automatic tick(input logic r, input logic [1:0] pa, input logic [1:0] pb);
    logic [6:0] e;
    reset = r;
    raw_a = pa;
    raw_b = pb;
    model_step(0, r, pa);
    model_step(1, r, pb);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("dut_a_outputs", {25'd0, lvl_a, prs_a, rel_a, any_a}, {25'd0, e});
    e = exp_q.pop_front();
    check_eq("dut_b_outputs", {25'd0, lvl_b, prs_b, rel_b, any_b}, {25'd0, e});
    seg_cyc++;
    if (prs_a[0]) begin
      press0_cnt++;
      if (first_press0 < 0) first_press0 = seg_cyc;
    end
    if (prs_a == 2'b11) both_press++;
    if (rel_a == 2'b11) both_rel++;
  endtask

  task automatic seg_start();
    seg_cyc      = 0;
    press0_cnt   = 0;
    first_press0 = -1;
    both_press   = 0;
    both_rel     = 0;
  endtask

  initial begin
    reset = 1'b1;
    raw_a = 2'b11;
    raw_b = 2'b11;
    seg_start();

    // held buttons through reset, then release reset
    repeat (3) tick(1'b1, 2'b11, 2'b11);
    check_eq("reset_level", {30'd0, lvl_a}, 32'd0);
    check_eq("reset_press", {30'd0, prs_a}, 32'd0);
    seg_start();
    repeat (10) tick(1'b0, 2'b11, 2'b11);
    check_eq("held_first_press_cycle", first_press0, 32'd6);
    check_eq("held_level", {30'd0, lvl_a}, 32'd3);

    // chatter every cycle never qualifies
    repeat (3) tick(1'b1, 2'b00, 2'b11);
    seg_start();
    for (int i = 0; i < 50; i++) tick(1'b0, {1'b0, i[0]}, 2'b11);
    check_eq("chatter_press_cnt", press0_cnt, 32'd0);
    check_eq("chatter_level", {30'd0, lvl_a}, 32'd0);

    // 3-high run ignored, 4-high run accepted
    repeat (6) tick(1'b0, 2'b00, 2'b11);
    seg_start();
    repeat (3) tick(1'b0, 2'b01, 2'b11);
    tick(1'b0, 2'b00, 2'b11);
    repeat (10) tick(1'b0, 2'b01, 2'b11);
    check_eq("run_press_cnt", press0_cnt, 32'd1);
    check_eq("run_first_press_cycle", first_press0, 32'd10);
    repeat (8) tick(1'b0, 2'b00, 2'b11);

    // both channels together
    seg_start();
    repeat (8) tick(1'b0, 2'b11, 2'b11);
    repeat (8) tick(1'b0, 2'b00, 2'b11);
    check_eq("both_press_cycles", both_press, 32'd1);
    check_eq("both_release_cycles", both_rel, 32'd1);
    check_eq("both_final_level", {30'd0, lvl_a}, 32'd0);

    // active-low instance
    repeat (8) tick(1'b0, 2'b00, 2'b00);
    check_eq("active_low_pressed", {30'd0, lvl_b}, 32'd3);
    repeat (8) tick(1'b0, 2'b00, 2'b11);
    check_eq("active_low_released", {30'd0, lvl_b}, 32'd0);

    // long hold, then reset mid-hold
    seg_start();
    repeat (30) tick(1'b0, 2'b01, 2'b11);
    check_eq("hold_press_cnt", press0_cnt, RPT_EN ? 32'd6 : 32'd1);
    repeat (2) tick(1'b1, 2'b01, 2'b11);
    check_eq("midhold_reset_level", {30'd0, lvl_a}, 32'd0);
    repeat (5) tick(1'b0, 2'b01, 2'b11);
    check_eq("after_reset_not_yet", {30'd0, lvl_a}, 32'd0);
    repeat (3) tick(1'b0, 2'b01, 2'b11);
    check_eq("after_reset_pressed", {30'd0, lvl_a}, 32'd1);
    repeat (8) tick(1'b0, 2'b00, 2'b11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
